// File: rtl/mst_fifo_rd_arb_if.sv
// FIFO-read / transmit bundle for the multi-channel read arbiter.
// master = arbiter side, slave = FIFO controller plus downstream sink.
interface mst_fifo_rd_arb_if;
  logic        mltcn;
  logic [3:0]  fifonempt;
  logic        fiford;
  logic [1:0]  fifordid;
  logic [35:0] fifo_dout;
  logic        tx_valid;
  logic [35:0] tx_data;
  logic [1:0]  tx_ch;
  logic        tx_last;
  logic        tx_ready;

  modport master (
    input  mltcn, fifonempt, fifo_dout, tx_ready,
    output fiford, fifordid, tx_valid, tx_data, tx_ch, tx_last
  );

  modport slave (
    output mltcn, fifonempt, fifo_dout, tx_ready,
    input  fiford, fifordid, tx_valid, tx_data, tx_ch, tx_last
  );
endinterface

// File: rtl/mst_fifo_rd_arb.sv
// Round-robin burst reader over four FIFO channels feeding a
// 2-entry skid buffer with valid/ready output.
module mst_fifo_rd_arb #(
  parameter int BURST_MAX = 16
) (
  input logic              clk,
  input logic              rst_n,
  mst_fifo_rd_arb_if.master bus
);

  typedef enum logic [1:0] {IDLE, BURST, TURN} state_t;

  localparam logic [8:0] BMAX_M1 = 9'(BURST_MAX - 1);

  state_t      st, st_nxt;
  logic [1:0]  cur_ch, cur_ch_nxt;
  logic [1:0]  last_ch, last_ch_nxt;
  logic [8:0]  cnt, cnt_nxt;
  logic        inf_vld, inf_max;
  logic [1:0]  inf_ch;
  logic [1:0]  occ;
  logic        rptr, wptr;
  logic [1:0][35:0] mem_d;
  logic [1:0][1:0]  mem_c;
  logic [1:0]       mem_l;
  logic        accept, push, pop, rd_ok, burst_end;
  logic        hit;
  logic [1:0]  sel, cand;

  assign push = inf_vld;
  assign pop  = bus.tx_valid && bus.tx_ready;

  // A same-cycle pop frees a slot, which keeps one word per cycle.
  assign rd_ok = ({1'b0, occ} + {2'b00, inf_vld})
               < (3'd2 + {2'b00, pop});

  assign bus.fiford   = (st == BURST) && rd_ok;
  assign bus.fifordid = cur_ch;
  assign accept       = bus.fiford && bus.fifonempt[cur_ch];
  assign burst_end    = accept && (cnt == BMAX_M1);

  always_comb begin
    hit  = 1'b0;
    sel  = last_ch;
    cand = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ch + 2'(i);
      if (!hit && bus.fifonempt[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
    if (!bus.mltcn) begin
      hit = bus.fifonempt[0];
      sel = 2'b00;
    end
  end

  always_comb begin
    st_nxt      = st;
    cur_ch_nxt  = cur_ch;
    last_ch_nxt = last_ch;
    cnt_nxt     = cnt;
    unique case (st)
      IDLE: begin
        cnt_nxt = '0;
        if (!bus.mltcn) cur_ch_nxt = 2'b00;
        if (hit) begin
          st_nxt      = BURST;
          cur_ch_nxt  = sel;
          last_ch_nxt = sel;
        end
      end
      BURST: begin
        if (accept) cnt_nxt = cnt + 9'd1;
        if (burst_end ||
            (!bus.fifonempt[cur_ch] && !inf_vld))
          st_nxt = TURN;
      end
      TURN:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      cur_ch  <= 2'b00;
      last_ch <= 2'd3;
      cnt     <= '0;
      inf_vld <= 1'b0;
      inf_ch  <= 2'b00;
      inf_max <= 1'b0;
    end else begin
      st      <= st_nxt;
      cur_ch  <= cur_ch_nxt;
      last_ch <= last_ch_nxt;
      cnt     <= cnt_nxt;
      inf_vld <= accept;
      inf_ch  <= cur_ch;
      inf_max <= burst_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ   <= 2'b00;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      mem_d <= '0;
      mem_c <= '0;
      mem_l <= '0;
    end else begin
      if (push) begin
        mem_d[wptr] <= bus.fifo_dout;
        mem_c[wptr] <= inf_ch;
        mem_l[wptr] <= inf_max || !bus.fifonempt[inf_ch];
        wptr        <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.tx_valid = (occ != 2'b00);
  assign bus.tx_data  = mem_d[rptr];
  assign bus.tx_ch    = mem_c[rptr];
  assign bus.tx_last  = mem_l[rptr];

endmodule

// File: tb/tb_mst_fifo_rd_arb.sv
// Directed bench for mst_fifo_rd_arb with a 4-channel FIFO model
// and a negedge monitor collecting transfers.
module tb_mst_fifo_rd_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nerr = 0;

  mst_fifo_rd_arb_if dif();

  mst_fifo_rd_arb #(.BURST_MAX(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.master)
  );

  always #5 clk = ~clk;

  int unsigned avail [4];
  int unsigned rd_cnt[4];

  always_comb begin
    dif.fifonempt = '0;
    for (int i = 0; i < 4; i++)
      dif.fifonempt[i] = avail[i] > rd_cnt[i];
  end

  // Word = {channel, 2'b00, per-channel sequence number}.
  always @(posedge clk) begin
    if (dif.fiford && dif.fifonempt[dif.fifordid]) begin
      dif.fifo_dout <= {dif.fifordid, 2'b00, rd_cnt[dif.fifordid]};
      rd_cnt[dif.fifordid] <= rd_cnt[dif.fifordid] + 1;
    end
  end

  logic [35:0] gd[$];
  logic [1:0]  gc[$];
  logic        gl[$];
  int          tc[$];
  int cyc = 0, acc = 0, pops = 0;
  int max_os = 0, viol = 0, unstable = 0;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [35:0] pd = '0;
  logic [1:0]  pc = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      acc  = 0;
      pops = 0;
      pv   = 1'b0;
    end else begin
      if (acc - pops > max_os) max_os = acc - pops;
      if (acc - pops >= 2 && !dif.tx_ready && dif.fiford) viol++;
      if (pv && !pr && (!dif.tx_valid || dif.tx_data !== pd ||
          dif.tx_ch !== pc || dif.tx_last !== pl))
        unstable++;
      if (dif.fiford && dif.fifonempt[dif.fifordid]) acc++;
      if (dif.tx_valid && dif.tx_ready) begin
        gd.push_back(dif.tx_data);
        gc.push_back(dif.tx_ch);
        gl.push_back(dif.tx_last);
        tc.push_back(cyc);
        pops++;
      end
      pv = dif.tx_valid;
      pr = dif.tx_ready;
      pd = dif.tx_data;
      pc = dif.tx_ch;
      pl = dif.tx_last;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int target, input string tag);
    int k = 0;
    while (gd.size() < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(gd.size() >= target), 1);
  endtask

  task automatic check_burst(input string tag, input int q0,
                             input int ch, input int s0, input int n);
    logic [38:0] e;
    for (int i = 0; i < n; i++) begin
      e = {(i == n - 1), 2'(ch), 2'(ch), 2'b00, 32'(s0 + i)};
      chk(tag, {gl[q0+i], gc[q0+i], gd[q0+i]}, e);
    end
  endtask

  task automatic wait_fiford(input bit need_acc, input string tag);
    int k = 0;
    while (!(dif.fiford &&
             (!need_acc || dif.fifonempt[dif.fifordid])) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(k < 200), 1);
  endtask

  initial begin
    int qb, bad, idx, n;
    int bs[4];
    rst_n        = 1'b0;
    dif.mltcn    = 1'b1;
    dif.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fiford",   dif.fiford,   0);
    chk("rst_fifordid", dif.fifordid, 0);
    chk("rst_tx_valid", dif.tx_valid, 0);
    chk("rst_tx_data",  dif.tx_data,  0);
    chk("rst_tx_ch",    dif.tx_ch,    0);
    chk("rst_tx_last",  dif.tx_last,  0);
    step();
    rst_n = 1'b1;

    // Only channel 2 non-empty, last granted = 3.
    step();
    qb    = gd.size();
    bs[2] = int'(rd_cnt[2]);
    avail[2] += 4;
    @(negedge clk);
    chk("rr_idle_cycle", dif.fiford, 0);
    @(negedge clk);
    chk("rr_grant", {dif.fiford, dif.fifordid}, 3'b110);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (dif.fifordid !== 2'd2) bad++;
    end
    chk("rr_hold_id", bad, 0);
    wait_n(qb + 4, "w35_cnt");
    check_burst("w35", qb, 2, bs[2], 4);

    // Single-channel mode: channel 3 must be ignored.
    step();
    dif.mltcn = 1'b0;
    qb    = gd.size();
    bs[0] = int'(rd_cnt[0]);
    bs[3] = int'(rd_cnt[3]);
    avail[0] += 5;
    avail[3] += 2;
    wait_n(qb + 5, "w32_cnt");
    check_burst("w32", qb, 0, bs[0], 5);
    for (int i = 1; i < 5; i++)
      chk("w32_gap", tc[qb+i] - tc[qb+i-1], 1);
    repeat (10) step();
    chk("w32_only_ch0", gd.size(), qb + 5);

    // Channel 1 empties after 3 words, then channel 3 follows.
    dif.mltcn = 1'b1;
    qb    = gd.size();
    bs[1] = int'(rd_cnt[1]);
    avail[1] += 3;
    wait_n(qb + 5, "w37_cnt");
    check_burst("w37a", qb, 1, bs[1], 3);
    check_burst("w37b", qb + 3, 3, bs[3], 2);
    chk("w37_turn_gap", tc[qb+3] - tc[qb+2], 5);

    // Reset while a read is in flight.
    step();
    bs[2] = int'(rd_cnt[2]);
    avail[2] += 5;
    @(negedge clk);
    wait_fiford(1'b1, "w36_acc_seen");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("w36_fiford",   dif.fiford,   0);
    chk("w36_tx_valid", dif.tx_valid, 0);
    chk("w36_fifordid", dif.fifordid, 0);
    for (int i = 0; i < 4; i++) avail[i] = rd_cnt[i];
    bs[0] = int'(rd_cnt[0]);
    bs[3] = int'(rd_cnt[3]);
    avail[0] += 2;
    avail[3] += 2;
    step();
    step();
    rst_n = 1'b1;
    qb = gd.size();
    @(negedge clk);
    wait_fiford(1'b0, "w36_grant_seen");
    chk("w36_first_id", dif.fifordid, 0);
    wait_n(qb + 4, "w36_cnt");
    check_burst("w36a", qb, 0, bs[0], 2);
    check_burst("w36b", qb + 2, 3, bs[3], 2);

    // Four channels, 40 words each, bursts of 16.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    qb = gd.size();
    for (int c = 0; c < 4; c++) begin
      bs[c] = int'(rd_cnt[c]);
      avail[c] += 40;
    end
    wait_n(qb + 160, "w33_cnt");
    idx = qb;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        n = (r < 2) ? 16 : 8;
        check_burst("w33", idx, c, bs[c] + 16 * r, n);
        idx += n;
      end

    // Back-pressure for 10 cycles mid-burst.
    step();
    qb    = gd.size();
    bs[0] = int'(rd_cnt[0]);
    avail[0] += 8;
    wait_n(qb + 2, "w34_pre");
    step();
    dif.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("w34_full_noread", dif.fiford,   0);
    chk("w34_held_valid",  dif.tx_valid, 1);
    repeat (7) step();
    dif.tx_ready = 1'b1;
    wait_n(qb + 8, "w34_cnt");
    repeat (10) step();
    chk("w34_no_dup", gd.size(), qb + 8);
    check_burst("w34", qb, 0, bs[0], 8);
    chk("w34_max_outstanding", 64'(max_os <= 2), 1);
    chk("w34_read_when_full", viol, 0);
    chk("stall_stability", unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
